// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED time-slice scheduler.
package led_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_SLOW  = 2'd1;
  localparam logic [1:0] PAT_FAST  = 2'd2;
  localparam logic [1:0] PAT_HEART = 2'd3;

  localparam int COL_GREEN   = 0;
  localparam int COL_RED     = 1;
  localparam int HEART_TICKS = 150;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from last+1.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         win,
  output logic [$clog2(N_REQ)-1:0] win_idx
);
  always_comb begin
    int idx;
    idx     = 0;
    win_idx = '0;
    // Walk from farthest to nearest so the nearest requester overwrites.
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      if (req[idx]) win_idx = idx[$clog2(N_REQ)-1:0];
    end
    win = '0;
    if (|req) win[win_idx] = 1'b1;
  end
endmodule

// File: rtl/led_sched.sv
// Round-robin time-slice owner of the green/red LED pair, with dark gaps and PWM dimming.
module led_sched import led_sched_pkg::*; #(
  parameter int N_REQ      = 4,
  parameter int TICK_DIV   = 24_000,
  parameter int SLOT_TICKS = 1000,
  parameter int GAP_TICKS  = 50,
  parameter int PWM_BITS   = 3,
  parameter int PWM_ON     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] color,
  input  logic [2*N_REQ-1:0] pattern,
  output logic [N_REQ-1:0]   grant,
  output logic               slot_done,
  output logic               led_green_n,
  output logic               led_red_n
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = $clog2(SLOT_TICKS);

  state_t              state, state_nxt;
  logic [PW-1:0]       pre;
  logic [TW-1:0]       t;
  logic [PWM_BITS-1:0] pwm;
  logic [IW-1:0]       last;
  logic [1:0]          color_q, pat_q;
  logic [N_REQ-1:0]    win;
  logic [IW-1:0]       win_idx;
  logic                tick, enter, take, done_nxt, pat_on, pwm_on, led_on;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req), .last(last), .win(win), .win_idx(win_idx)
  );

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_nxt = GRANT;
        take      = 1'b1;
      end
      GRANT: if (!req[last] || (tick && t == TW'(SLOT_TICKS - 1))) begin
        state_nxt = GAP;
        done_nxt  = 1'b1;
      end
      GAP: if (tick && t == TW'(GAP_TICKS - 1)) begin
        if (|req) begin
          state_nxt = GRANT;
          take      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Timebase restarts on every slot/gap entry so their lengths are exact.
    enter = (state_nxt != state) && (state_nxt != IDLE);
  end

  always_comb begin
    case (pat_q)
      PAT_SOLID: pat_on = 1'b1;
      PAT_SLOW:  pat_on = int'(t) < SLOT_TICKS / 2;
      PAT_FAST:  pat_on = ~t[6];
      default:   pat_on = int'(t) < HEART_TICKS;
    endcase
    pwm_on = int'(pwm) < PWM_ON;
    led_on = (state == GRANT) && pat_on && pwm_on;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pre         <= '0;
      t           <= '0;
      pwm         <= '0;
      last        <= IW'(N_REQ - 1);
      color_q     <= '0;
      pat_q       <= '0;
      grant       <= '0;
      slot_done   <= 1'b0;
      led_green_n <= 1'b1;
      led_red_n   <= 1'b1;
    end else begin
      state     <= state_nxt;
      slot_done <= done_nxt;
      pwm       <= pwm + 1'b1;
      if (enter) begin
        pre <= '0;
        t   <= '0;
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) t <= t + 1'b1;
      end
      if (take) begin
        last    <= win_idx;
        color_q <= color[{win_idx, 1'b0} +: 2];
        pat_q   <= pattern[{win_idx, 1'b0} +: 2];
        grant   <= win;
      end else if (state_nxt != GRANT) begin
        grant <= '0;
      end
      led_green_n <= ~(led_on & color_q[COL_GREEN]);
      led_red_n   <= ~(led_on & color_q[COL_RED]);
    end
  end
endmodule

// File: tb/tb_led_sched.sv
// Randomized scoreboard bench for led_sched against a cycle-count reference model.
module tb_led_sched;
  localparam int N = 4, DIV = 4, SLOT = 256, GAPT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [7:0]   color = '0, pattern = '0;
  logic [N-1:0] grant;
  logic         slot_done, led_green_n, led_red_n;

  led_sched #(.N_REQ(N), .TICK_DIV(DIV), .SLOT_TICKS(SLOT), .GAP_TICKS(GAPT),
              .PWM_BITS(3), .PWM_ON(1)) dut (
    .clk(clk), .reset(reset), .req(req), .color(color), .pattern(pattern),
    .grant(grant), .slot_done(slot_done), .led_green_n(led_green_n), .led_red_n(led_red_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         d, gn, rn;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  // Reference model: slot/gap tracked as elapsed cycles; ticks are elapsed/DIV.
  int mode = 0, e = 0, owner = 0, last = N - 1, pc = 0;
  logic [1:0] m_col = '0, m_pat = '0;

  function automatic bit pat_on(input logic [1:0] p, input int tk);
    case (p)
      2'd0:    return 1'b1;
      2'd1:    return tk < SLOT / 2;
      2'd2:    return (tk / 64) % 2 == 0;
      default: return tk < 150;
    endcase
  endfunction

  task automatic start_slot();
    for (int i = N; i >= 1; i--)
      if (req[(last + i) % N]) owner = (last + i) % N;
    last  = owner;
    m_col = color[2*owner +: 2];
    m_pat = pattern[2*owner +: 2];
    mode  = 1;
    e     = 0;
  endtask

  always @(posedge clk) begin
    exp_t x;
    bit lon;
    if (reset) begin
      mode = 0; e = 0; last = N - 1; pc = 0;
      x = '{g: '0, d: 1'b0, gn: 1'b1, rn: 1'b1};
    end else begin
      lon  = (mode == 1) && pat_on(m_pat, e / DIV) && (pc < 1);
      x.gn = !(lon && m_col[0]);
      x.rn = !(lon && m_col[1]);
      x.d  = 1'b0;
      pc   = (pc + 1) % 8;
      case (mode)
        0: if (req != 0) start_slot();
        1: if (!req[owner] || e == SLOT * DIV - 1) begin
             mode = 2; e = 0; x.d = 1'b1;
           end else e++;
        default: if (e == GAPT * DIV - 1) begin
             if (req != 0) start_slot(); else mode = 0;
           end else e++;
      endcase
      x.g = (mode == 1) ? N'(1 << owner) : '0;
    end
    q.push_back(x);
  end

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      x = q.pop_front();
      chk("grant", int'(grant), int'(x.g));
      chk("slot_done", int'(slot_done), int'(x.d));
      chk("led_green_n", int'(led_green_n), int'(x.gn));
      chk("led_red_n", int'(led_red_n), int'(x.rn));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int waited;
    cyc(3);
    reset = 1'b0;
    cyc(30);                                   // idle: nothing lit, no grant
    req = 4'b0001; color = 8'h01; pattern = 8'h00;
    cyc(1024 + 8 + 100);                       // full slot, gap, re-grant
    req = 4'b0000;
    cyc(20);
    req = 4'b1011; color = 8'($urandom); pattern = 8'($urandom);
    cyc(500);
    color = 8'($urandom); pattern = 8'($urandom);  // mid-slot change, latched later
    cyc(3700);
    req = 4'b0000;
    cyc(20);
    req = 4'b0001; color = 8'h03;              // early release 100 cycles in
    cyc(100);
    req = 4'b0000;
    cyc(20);
    for (int p = 1; p <= 3; p++) begin
      req = 4'b0001; color = 8'($urandom_range(1, 3)); pattern = {4{2'(p)}};
      cyc(1030);
      req = 4'b0000;
      cyc(20);
    end
    for (int k = 0; k < 12; k++) begin
      req = 4'($urandom); color = 8'($urandom); pattern = 8'($urandom);
      cyc($urandom_range(20, 600));
    end
    req = 4'b0000;
    cyc(20);
    req = 4'b0100; color = 8'hFF; pattern = 8'h00;
    waited = 0;
    while (grant != 4'b0100 && waited < 100) begin
      cyc(1);
      waited++;
    end
    if (waited >= 100) chk("wait_grant2_timeout", 1, 0);
    cyc(100);
    reset = 1'b1;
    #1;
    chk("reset_grant", int'(grant), 0);
    chk("reset_slot_done", int'(slot_done), 0);
    chk("reset_green", int'(led_green_n), 1);
    chk("reset_red", int'(led_red_n), 1);
    cyc(3);
    req = 4'b0110;
    reset = 1'b0;
    cyc(2);
    chk("post_reset_grant1", int'(grant), 2);
    cyc(1100);
    req = 4'b0000;
    cyc(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
